countdown_timer_gen: RTL and testbench
======================================

Name: countdown_timer_gen

Overview:
Parametrised successor to the minute/second egg-timer counter. The whole block runs in one synchronous domain on clk. A one-cycle tick strobe replaces the gated 1 Hz clock and the seconds-overflow clock. Adds:
- count-up (stopwatch) mode
- auto-reload from stored presets
- load clamping
- a done pulse
- a timed, acknowledgeable alarm

Sits between the button/switch front end and the display driver.

Parameters:
MIN_W, 7, width of the minutes field
SEC_W, 6, width of the seconds field
MIN_MAX, 99, largest minutes value (must fit MIN_W)
SEC_MAX, 59, largest seconds value (must fit SEC_W)
ALARM_TICKS, 10, number of ticks the alarm stays high without ack (≥1)

Ports:
clk  in  1  system clock; all state on rising edge
reset  in  1  asynchronous, active-low reset
tick  in  1  one-cycle count strobe (1 Hz nominal); ignored when high >1 cycle only in that each high cycle counts
enable  in  1  run/pause
mode_up  in  1  0 = count down, 1 = count up
auto_reload  in  1  down mode: reload presets on expiry
clear  in  1  synchronous clear of min/sec/alarm
load_min  in  1  load val_min into min and the minutes preset
load_sec  in  1  load val_sec into sec and the seconds preset
val_min  in  MIN_W  minutes load value
val_sec  in  SEC_W  seconds load value
alarm_ack  in  1  clears alarm
min  out  MIN_W  current minutes
sec  out  SEC_W  current seconds
running  out  1  enable & ~done
done  out  1  level: terminal value reached
done_pulse  out  1  one cycle on entry to terminal value
alarm  out  1  alarm output

Behaviour:
- Reset (low, async): min, sec, presets = 0; alarm = 0; done_pulse = 0; alarm counter = 0.
  - done = 1 after reset in down mode, because 00:00 is terminal.
- Terminal value:
  - Down mode: 00:00.
  - Up mode: MIN_MAX:SEC_MAX.
  - done is combinational from min, sec and mode_up.
- Priority per cycle: clear > load > tick.
- clear: min = sec = 0, alarm = 0, alarm counter = 0. Presets are unchanged.
- Loads:
  - load_min and load_sec are independent and may be simultaneous.
  - A value above MAX is clamped to MAX.
  - The clamped value is written to both the field and its preset.
  - A tick in the same cycle as any load is discarded.
- Counting happens only when tick & enable & no clear/load, and is a single-cycle registered update.
- Down mode, not done:
  - sec > 0: sec − 1.
  - sec = 0: sec = SEC_MAX, min − 1.
- Down mode, done:
  - auto_reload = 1: min, sec = presets. If the presets are 00:00, stay at 00:00.
  - auto_reload = 0: hold at 00:00 (no underflow).
- Up mode, not done:
  - sec < SEC_MAX: sec + 1.
  - else sec = 0, min + 1.
- Up mode, done: saturate and hold. auto_reload is ignored.
- Changing mode_up mid-count takes effect on the next tick. There is no value change on the switch itself.
- done_pulse:
  - Registered; high for exactly one cycle, the cycle after the counting update that makes the value terminal. It coincides with the first cycle min/sec show the terminal value.
  - Not asserted by load, clear or reset.
  - Not asserted by a mode switch that makes the current value terminal.
- alarm:
  - Set together with done_pulse; alarm counter = 0.
  - While alarm = 1, each tick (regardless of enable) increments the counter.
  - alarm clears when the counter reaches ALARM_TICKS, or on alarm_ack (highest priority after reset/clear).
  - A new done_pulse while the alarm is high restarts the counter.
  - If alarm_ack coincides with a new done_pulse, the alarm stays set.
- running = enable & ~done.
- Latency: tick to updated min/sec is 1 cycle. No combinational path from tick to any output except via registers.

Test Plan:
1. Reset low mid-count at 02:17 → min=0, sec=0, alarm=0, done=1 immediately (async); after release, load_min=1, val_min=1, load_sec=1, val_sec=2 → 01:02, done=0.
2. From 01:02, down, enable=1, 3 ticks → 01:01, 01:00, 00:59; 59 more ticks → 00:00, done_pulse high one cycle, alarm=1; 10 further ticks → alarm=0 on the 10th; extra ticks hold 00:00.
3. Preset 00:02, auto_reload=1, down: ticks → 00:01, 00:00 (done_pulse), next tick → 00:02, done=0; second expiry gives a second done_pulse.
4. load_min=1 with val_min=120, and load_sec=1 with val_sec=63, plus tick in the same cycle → min=99, sec=59, tick ignored; mode_up=1 gives done=1 with no done_pulse; one tick → holds 99:59.
5. Up mode from 98:58: ticks → 98:59, 99:00 … 99:59 with done_pulse on entry; alarm_ack after 3 ticks → alarm=0 next cycle.
6. enable=0 with tick pulses at 00:05 → value unchanged, running=0; clear while alarm=1 → 00:00, alarm=0, no done_pulse; presets retained.

Source files
------------

// File: rtl/countdown_timer_gen.sv
// countdown_timer_gen: minute/second timer with count-down and count-up
// (stopwatch) modes, clamped loads with stored presets, auto-reload on
// expiry, a one-cycle done pulse and a tick-timed, acknowledgeable alarm.
// Single clock domain; tick is a one-cycle count strobe.

module countdown_timer_gen #(
    parameter int unsigned MIN_W       = 7,
    parameter int unsigned SEC_W       = 6,
    parameter int unsigned MIN_MAX     = 99,
    parameter int unsigned SEC_MAX     = 59,
    parameter int unsigned ALARM_TICKS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             enable,
    input  logic             mode_up,
    input  logic             auto_reload,
    input  logic             clear,
    input  logic             load_min,
    input  logic             load_sec,
    input  logic [MIN_W-1:0] val_min,
    input  logic [SEC_W-1:0] val_sec,
    input  logic             alarm_ack,
    output logic [MIN_W-1:0] min,
    output logic [SEC_W-1:0] sec,
    output logic             running,
    output logic             done,
    output logic             done_pulse,
    output logic             alarm
);

    localparam logic [MIN_W-1:0]  MIN_TOP  = MIN_W'(MIN_MAX);
    localparam logic [SEC_W-1:0]  SEC_TOP  = SEC_W'(SEC_MAX);
    localparam int unsigned       ACNT_W   = $clog2(ALARM_TICKS + 1);
    localparam logic [ACNT_W-1:0] ACNT_TOP = ACNT_W'(ALARM_TICKS);

    // Time fields and presets
    logic [MIN_W-1:0]  min_q, min_d;
    logic [SEC_W-1:0]  sec_q, sec_d;
    logic [MIN_W-1:0]  pre_min_q, pre_min_d;
    logic [SEC_W-1:0]  pre_sec_q, pre_sec_d;

    // Done pulse and alarm state
    logic              done_pulse_q, done_pulse_d;
    logic              alarm_q, alarm_d;
    logic [ACNT_W-1:0] alarm_cnt_q, alarm_cnt_d;

    // Per-cycle decode
    logic              load_any;
    logic              count_en;
    logic              done_now;
    logic              done_next;
    logic [MIN_W-1:0]  ld_min;
    logic [SEC_W-1:0]  ld_sec;
    logic [ACNT_W-1:0] alarm_cnt_inc;

    // Terminal value depends on direction: 00:00 down, MAX:MAX up.
    function automatic logic is_terminal(
        input logic             up,
        input logic [MIN_W-1:0] m,
        input logic [SEC_W-1:0] s
    );
        if (up) begin
            return (m == MIN_TOP) && (s == SEC_TOP);
        end
        return (m == '0) && (s == '0);
    endfunction

    // Strobe qualification, load clamping and terminal detection
    always_comb begin
        load_any      = load_min | load_sec;
        count_en      = tick & enable & ~clear & ~load_any;
        ld_min        = (val_min > MIN_TOP) ? MIN_TOP : val_min;
        ld_sec        = (val_sec > SEC_TOP) ? SEC_TOP : val_sec;
        done_now      = is_terminal(mode_up, min_q, sec_q);
        alarm_cnt_inc = alarm_cnt_q + ACNT_W'(1);
    end

    // Next min/sec/preset value: clear > load > counting tick
    always_comb begin
        min_d     = min_q;
        sec_d     = sec_q;
        pre_min_d = pre_min_q;
        pre_sec_d = pre_sec_q;
        if (clear) begin
            min_d = '0;
            sec_d = '0;
        end else if (load_any) begin
            if (load_min) begin
                min_d     = ld_min;
                pre_min_d = ld_min;
            end
            if (load_sec) begin
                sec_d     = ld_sec;
                pre_sec_d = ld_sec;
            end
        end else if (count_en) begin
            if (!mode_up) begin
                if (!done_now) begin
                    if (sec_q != '0) begin
                        sec_d = sec_q - SEC_W'(1);
                    end else begin
                        sec_d = SEC_TOP;
                        min_d = min_q - MIN_W'(1);
                    end
                end else if (auto_reload) begin
                    // Presets of 00:00 simply reload 00:00.
                    min_d = pre_min_q;
                    sec_d = pre_sec_q;
                end
            end else if (!done_now) begin
                if (sec_q < SEC_TOP) begin
                    sec_d = sec_q + SEC_W'(1);
                end else begin
                    sec_d = '0;
                    min_d = min_q + MIN_W'(1);
                end
            end
        end
    end

    // Done pulse only on a counting update that enters the terminal value;
    // loads, clears and mode switches never produce one.
    always_comb begin
        done_next    = is_terminal(mode_up, min_d, sec_d);
        done_pulse_d = count_en & ~done_now & done_next;
    end

    // Alarm: set with the done pulse (wins over a coincident ack), times out
    // after ALARM_TICKS ticks regardless of enable, cleared by ack or clear.
    always_comb begin
        alarm_d     = alarm_q;
        alarm_cnt_d = alarm_cnt_q;
        if (clear) begin
            alarm_d     = 1'b0;
            alarm_cnt_d = '0;
        end else if (done_pulse_d) begin
            alarm_d     = 1'b1;
            alarm_cnt_d = '0;
        end else if (alarm_ack) begin
            alarm_d     = 1'b0;
            alarm_cnt_d = '0;
        end else if (alarm_q && tick) begin
            if (alarm_cnt_inc >= ACNT_TOP) begin
                alarm_d     = 1'b0;
                alarm_cnt_d = '0;
            end else begin
                alarm_cnt_d = alarm_cnt_inc;
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            min_q        <= '0;
            sec_q        <= '0;
            pre_min_q    <= '0;
            pre_sec_q    <= '0;
            done_pulse_q <= 1'b0;
            alarm_q      <= 1'b0;
            alarm_cnt_q  <= '0;
        end else begin
            min_q        <= min_d;
            sec_q        <= sec_d;
            pre_min_q    <= pre_min_d;
            pre_sec_q    <= pre_sec_d;
            done_pulse_q <= done_pulse_d;
            alarm_q      <= alarm_d;
            alarm_cnt_q  <= alarm_cnt_d;
        end
    end

    assign min        = min_q;
    assign sec        = sec_q;
    assign done       = done_now;
    assign running    = enable & ~done_now;
    assign done_pulse = done_pulse_q;
    assign alarm      = alarm_q;

endmodule

// File: tb/tb_countdown_timer_gen.sv
// Self-checking bench for countdown_timer_gen: expected snapshots are pushed
// to a scoreboard queue as stimulus is driven and popped after the edge.

module tb_countdown_timer_gen;

    typedef struct packed {
        logic [6:0] m;
        logic [5:0] s;
        logic       done;
        logic       dp;
        logic       alarm;
        logic       run;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       enable = 1'b0;
    logic       mode_up = 1'b0;
    logic       auto_reload = 1'b0;
    logic       clear = 1'b0;
    logic       load_min = 1'b0;
    logic       load_sec = 1'b0;
    logic [6:0] val_min = '0;
    logic [5:0] val_sec = '0;
    logic       alarm_ack = 1'b0;
    logic [6:0] min;
    logic [5:0] sec;
    logic       running;
    logic       done;
    logic       done_pulse;
    logic       alarm;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    exp_t got;
    exp_t want;

    countdown_timer_gen #(
        .MIN_W(7),
        .SEC_W(6),
        .MIN_MAX(99),
        .SEC_MAX(59),
        .ALARM_TICKS(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tick(tick),
        .enable(enable),
        .mode_up(mode_up),
        .auto_reload(auto_reload),
        .clear(clear),
        .load_min(load_min),
        .load_sec(load_sec),
        .val_min(val_min),
        .val_sec(val_sec),
        .alarm_ack(alarm_ack),
        .min(min),
        .sec(sec),
        .running(running),
        .done(done),
        .done_pulse(done_pulse),
        .alarm(alarm)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input int m, input int s, input bit d,
                                input bit p, input bit a, input bit r);
        exp_t e;
        e.m     = 7'(m);
        e.s     = 6'(s);
        e.done  = d;
        e.dp    = p;
        e.alarm = a;
        e.run   = r;
        return e;
    endfunction

    function automatic exp_t sample();
        exp_t e;
        e.m     = min;
        e.s     = sec;
        e.done  = done;
        e.dp    = done_pulse;
        e.alarm = alarm;
        e.run   = running;
        return e;
    endfunction

    function automatic string fmt(input exp_t e);
        return $sformatf("%0d:%0d done=%b dp=%b alarm=%b run=%b",
                         e.m, e.s, e.done, e.dp, e.alarm, e.run);
    endfunction

    // One clock: sample point is 1 time unit after the rising edge, then
    // single-cycle strobes are dropped.
    task automatic step();
        @(posedge clk);
        #1;
        tick      = 1'b0;
        load_min  = 1'b0;
        load_sec  = 1'b0;
        clear     = 1'b0;
        alarm_ack = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin
                    exp_q.push_back(mk(0, 0, 1, 0, 0, 0));
                    repeat (2) @(posedge clk);
                    #1;
                end
                1: begin
                    reset = 1'b1; enable = 1'b1;
                    load_min = 1'b1; val_min = 7'd2;
                    load_sec = 1'b1; val_sec = 6'd17;
                    exp_q.push_back(mk(2, 17, 0, 0, 0, 1));
                    step();
                end
                2: begin
                    exp_q.push_back(mk(0, 0, 1, 0, 0, 0));
                    #3 reset = 1'b0;
                    #1;
                end
                default: begin
                    reset = 1'b1;
                    load_min = 1'b1; val_min = 7'd1;
                    load_sec = 1'b1; val_sec = 6'd2;
                    exp_q.push_back(mk(1, 2, 0, 0, 0, 1));
                    step();
                end
            endcase
            got = sample(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL reset[%0d]: got %s, want %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_countdown();
        int v;
        // 01:02 is 62 seconds; one second per tick down to 00:00.
        for (int k = 1; k <= 62; k++) begin
            tick = 1'b1;
            v = 62 - k;
            exp_q.push_back(mk(v / 60, v % 60, v == 0, v == 0, v == 0, v != 0));
            step();
            got = sample(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL countdown[%0d]: got %s, want %s", k, fmt(got), fmt(want));
            end
        end
        // Alarm stays for 9 further ticks, drops on the 10th; value holds.
        for (int k = 1; k <= 12; k++) begin
            tick = 1'b1;
            exp_q.push_back(mk(0, 0, 1, 0, k < 10, 0));
            step();
            got = sample(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL alarm_timeout[%0d]: got %s, want %s", k, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_auto_reload();
        auto_reload = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 0) begin
                load_min = 1'b1; val_min = 7'd0;
                load_sec = 1'b1; val_sec = 6'd2;
                exp_q.push_back(mk(0, 2, 0, 0, 0, 1));
            end else if (i == 1) begin
                tick = 1'b1; exp_q.push_back(mk(0, 1, 0, 0, 0, 1));
            end else if (i == 2) begin
                tick = 1'b1; exp_q.push_back(mk(0, 0, 1, 1, 1, 0));
            end else if (i == 3) begin
                tick = 1'b1; exp_q.push_back(mk(0, 2, 0, 0, 1, 1));
            end else if (i == 4) begin
                tick = 1'b1; exp_q.push_back(mk(0, 1, 0, 0, 1, 1));
            end else if (i == 5) begin
                // ack coincides with the expiry: alarm stays, counter restarts
                tick = 1'b1; alarm_ack = 1'b1;
                exp_q.push_back(mk(0, 0, 1, 1, 1, 0));
            end else if (i < 15) begin
                auto_reload = 1'b0;
                tick = 1'b1; exp_q.push_back(mk(0, 0, 1, 0, 1, 0));
            end else begin
                alarm_ack = 1'b1; exp_q.push_back(mk(0, 0, 1, 0, 0, 0));
            end
            step();
            got = sample(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL auto_reload[%0d]: got %s, want %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_load_clamp();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin
                    load_min = 1'b1; val_min = 7'd120;
                    load_sec = 1'b1; val_sec = 6'd63;
                    tick = 1'b1;
                    exp_q.push_back(mk(99, 59, 0, 0, 0, 1));
                end
                1: begin
                    mode_up = 1'b1;
                    exp_q.push_back(mk(99, 59, 1, 0, 0, 0));
                end
                2: begin
                    tick = 1'b1;
                    exp_q.push_back(mk(99, 59, 1, 0, 0, 0));
                end
                default: begin
                    mode_up = 1'b0;
                    load_sec = 1'b1; val_sec = 6'd30;
                    exp_q.push_back(mk(99, 30, 0, 0, 0, 1));
                end
            endcase
            step();
            got = sample(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL load_clamp[%0d]: got %s, want %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_count_up();
        int v;
        mode_up = 1'b1;
        for (int i = 0; i < 66; i++) begin
            if (i == 0) begin
                load_min = 1'b1; val_min = 7'd98;
                load_sec = 1'b1; val_sec = 6'd58;
                exp_q.push_back(mk(98, 58, 0, 0, 0, 1));
            end else if (i <= 61) begin
                // 98:58 is 5938 s; 99:59 (5999 s) is reached on tick 61.
                tick = 1'b1;
                v = 5938 + i;
                exp_q.push_back(mk(v / 60, v % 60, v == 5999, v == 5999, v == 5999, v != 5999));
            end else if (i <= 64) begin
                auto_reload = 1'b1;
                tick = 1'b1;
                exp_q.push_back(mk(99, 59, 1, 0, 1, 0));
            end else begin
                alarm_ack = 1'b1;
                exp_q.push_back(mk(99, 59, 1, 0, 0, 0));
            end
            step();
            got = sample(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL count_up[%0d]: got %s, want %s", i, fmt(got), fmt(want));
            end
        end
        auto_reload = 1'b0;
    endtask

    task automatic test_pause_clear();
        mode_up = 1'b0;
        enable  = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (i == 0) begin
                load_min = 1'b1; val_min = 7'd0;
                load_sec = 1'b1; val_sec = 6'd5;
                exp_q.push_back(mk(0, 5, 0, 0, 0, 0));
            end else if (i <= 3) begin
                tick = 1'b1;
                exp_q.push_back(mk(0, 5, 0, 0, 0, 0));
            end else if (i <= 8) begin
                enable = 1'b1; auto_reload = 1'b1; tick = 1'b1;
                exp_q.push_back(mk(0, 8 - i, i == 8, i == 8, i == 8, i != 8));
            end else if (i == 9) begin
                tick = 1'b1; exp_q.push_back(mk(0, 5, 0, 0, 1, 1));
            end else if (i == 10) begin
                tick = 1'b1; exp_q.push_back(mk(0, 4, 0, 0, 1, 1));
            end else if (i == 11) begin
                clear = 1'b1; tick = 1'b1;
                exp_q.push_back(mk(0, 0, 1, 0, 0, 0));
            end else if (i == 12) begin
                tick = 1'b1; exp_q.push_back(mk(0, 5, 0, 0, 0, 1));
            end else if (i == 13) begin
                mode_up = 1'b1; exp_q.push_back(mk(0, 5, 0, 0, 0, 1));
            end else begin
                tick = 1'b1; exp_q.push_back(mk(0, 6, 0, 0, 0, 1));
            end
            step();
            got = sample(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL pause_clear[%0d]: got %s, want %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_auto_reload();
        test_load_clamp();
        test_count_up();
        test_pause_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
